// File: rtl/bus_port_bridge.sv
// bus_port_bridge: samples an asynchronous strobe bus in the clk200 domain and routes each
// access to chip memory (single-cycle pulses) or to the emulation CPU (toggle req/ack).
module bus_port_bridge #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 4,
   parameter int SYNC_STAGES = 2,
   parameter int SETTLE_CYCLES = 1,
   parameter logic [ADDR_W-1:0] BYPASS_ADDR = ADDR_W'('hd),
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk200,
   input  logic              reset,
   input  logic              BUS_RD_n,
   input  logic              BUS_WR_n,
   input  logic [ADDR_W-1:0] BUS_A,
   inout  wire  [DATA_W-1:0] BUS_D,
   input  logic              cmem_bank,
   output logic              emu_rd_req,
   input  logic              emu_rd_ack,
   output logic              emu_wr_req,
   input  logic              emu_wr_ack,
   input  logic [DATA_W-1:0] emu_rdata,
   output logic              cmem_rd,
   output logic              cmem_wr,
   input  logic [DATA_W-1:0] cmem_rdata,
   output logic [ADDR_W-1:0] addr_out,
   output logic [DATA_W-1:0] wdata_out,
   output logic              timeout_err,
   output logic              busy
);
   localparam int CW = $clog2(SETTLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
   typedef enum logic [2:0] {IDLE, SETTLE, DISPATCH, CMEM, WAIT_EMU, RELEASE} state_t;
   state_t state, state_nx;
   logic [SYNC_STAGES-1:0] rd_sync, wr_sync;
   logic [CW-1:0] cnt;
   logic [TW-1:0] timer;
   logic [DATA_W-1:0] hold, d_drive;
   logic rd_s, wr_s, is_rd, src_emu, route, settle_done, emu_done, timed_out;

   assign rd_s = rd_sync[SYNC_STAGES-1];
   assign wr_s = wr_sync[SYNC_STAGES-1];
   assign route = cmem_bank && addr_out != BYPASS_ADDR;
   assign settle_done = cnt == CW'(SETTLE_CYCLES - 1);
   assign emu_done = is_rd ? emu_rd_req == emu_rd_ack : emu_wr_req == emu_wr_ack;
   assign timed_out = TIMEOUT_CYCLES != 0 && timer == TW'(TIMEOUT_CYCLES - 1);
   assign busy = state != IDLE;

   always_ff @(posedge clk200) begin
      if (reset) state <= IDLE;
      else state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     state_nx = (rd_s || wr_s) ? SETTLE : IDLE;
         SETTLE:   state_nx = !(rd_s || wr_s) ? IDLE : settle_done ? DISPATCH : SETTLE;
         DISPATCH: state_nx = route ? CMEM : WAIT_EMU;
         CMEM:     state_nx = RELEASE;
         WAIT_EMU: state_nx = (emu_done || timed_out) ? RELEASE : WAIT_EMU;
         RELEASE:  state_nx = (rd_s || wr_s) ? RELEASE : IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk200) begin
      if (reset) begin
         rd_sync <= '0;
         wr_sync <= '0;
         cnt <= '0;
         timer <= '0;
         is_rd <= 1'b0;
         src_emu <= 1'b0;
         emu_rd_req <= 1'b0;
         emu_wr_req <= 1'b0;
         cmem_rd <= 1'b0;
         cmem_wr <= 1'b0;
         timeout_err <= 1'b0;
         addr_out <= '0;
         wdata_out <= '0;
         hold <= '0;
      end else begin
         rd_sync <= {rd_sync[SYNC_STAGES-2:0], ~BUS_RD_n};
         wr_sync <= {wr_sync[SYNC_STAGES-2:0], ~BUS_WR_n};
         cnt <= (state == SETTLE) ? cnt + 1'b1 : '0;
         timer <= (state == WAIT_EMU) ? timer + 1'b1 : '0;
         cmem_rd <= state == DISPATCH && route && is_rd;
         cmem_wr <= state == DISPATCH && route && !is_rd;
         timeout_err <= state == WAIT_EMU && !emu_done && timed_out;
         if (state == IDLE || (state == SETTLE && !settle_done)) begin
            addr_out <= BUS_A;
            wdata_out <= BUS_D;
         end
         if (state == IDLE || state == SETTLE) is_rd <= rd_s;
         // Next request is built from the ack, so a late ack after a timeout cannot cause a double toggle
         if (state == DISPATCH) begin
            src_emu <= !route;
            if (!route && is_rd) emu_rd_req <= ~emu_rd_ack;
            if (!route && !is_rd) emu_wr_req <= ~emu_wr_ack;
         end
         if (state == WAIT_EMU && is_rd && emu_done) hold <= emu_rdata;
         else if (state == WAIT_EMU && !emu_done && timed_out) hold <= '0;
      end
   end

   always_comb begin
      d_drive = (state == CMEM || (state == RELEASE && !src_emu)) ? cmem_rdata :
                (state == RELEASE) ? hold : '0;
   end

   assign BUS_D = BUS_RD_n ? 'z : d_drive;
endmodule

// File: tb/tb_bus_port_bridge.sv
// tb_bus_port_bridge: directed bus accesses with a scoreboard of expected pulses, toggles and timeouts.
module tb_bus_port_bridge;
   localparam int CRD = 0, CWR = 1, ERD = 2, EWR = 3, TMO = 4;
   typedef struct {
      int kind;
      logic [3:0] addr;
      logic [3:0] data;
   } ev_t;

   logic clk200 = 0, reset = 1, rd_n = 1, wr_n = 1, cmem_bank = 0;
   logic emu_rd_ack = 0, emu_wr_ack = 0, tb_den = 0;
   logic [3:0] a = 0, emu_rdata = 0, cmem_rdata = 4'ha, tb_d = 0;
   logic emu_rd_req, emu_wr_req, cmem_rd, cmem_wr, timeout_err, busy;
   logic [3:0] addr_out, wdata_out;
   wire [3:0] bus_d;
   ev_t q[$];
   int errors = 0, checks = 0;
   logic prev_rq = 0, prev_wq = 0;

   assign bus_d = tb_den ? tb_d : 'z;
   always #5 clk200 = ~clk200;

   bus_port_bridge #(.SETTLE_CYCLES(3), .TIMEOUT_CYCLES(16)) dut (
      .clk200(clk200), .reset(reset), .BUS_RD_n(rd_n), .BUS_WR_n(wr_n), .BUS_A(a),
      .BUS_D(bus_d), .cmem_bank(cmem_bank), .emu_rd_req(emu_rd_req), .emu_rd_ack(emu_rd_ack),
      .emu_wr_req(emu_wr_req), .emu_wr_ack(emu_wr_ack), .emu_rdata(emu_rdata),
      .cmem_rd(cmem_rd), .cmem_wr(cmem_wr), .cmem_rdata(cmem_rdata), .addr_out(addr_out),
      .wdata_out(wdata_out), .timeout_err(timeout_err), .busy(busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic sb(input int kind);
      if (q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event: got kind %0d expected none", kind);
      end else begin
         ev_t e;
         e = q.pop_front();
         chk("event_kind", kind, e.kind);
         chk("event_addr", addr_out, e.addr);
         if (kind == EWR) chk("event_wdata", wdata_out, e.data);
      end
   endtask

   always @(negedge clk200) begin
      if (cmem_rd) sb(CRD);
      if (cmem_wr) sb(CWR);
      if (emu_rd_req != prev_rq) sb(ERD);
      if (emu_wr_req != prev_wq) sb(EWR);
      if (timeout_err) sb(TMO);
      prev_rq = emu_rd_req;
      prev_wq = emu_wr_req;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk200);
      #2;
   endtask

   task automatic wait_toggle(input bit rd);
      int i;
      for (i = 0; i < 40 && (rd ? emu_rd_req == emu_rd_ack : emu_wr_req == emu_wr_ack); i++) step(1);
      chk("req_toggle_seen", i < 40, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      // reset held while strobes toggle
      step(2);
      repeat (3) begin
         cmem_bank = 1;
         a = 3;
         rd_n = 0;
         step(2);
         chk("rst_busd", bus_d, 0);
         chk("rst_busy", busy, 0);
         rd_n = 1;
         wr_n = 0;
         step(2);
         wr_n = 1;
      end
      chk("rst_rd_req", emu_rd_req, 0);
      chk("rst_wr_req", emu_wr_req, 0);
      chk("rst_addr", addr_out, 0);
      chk("rst_wdata", wdata_out, 0);
      chk("rst_timeout", timeout_err, 0);
      reset = 0;
      step(5);
      // chip-memory read
      q.push_back('{CRD, 4'h3, 4'h0});
      rd_n = 0;
      step(12);
      chk("cmem_rd_busd", bus_d, 4'ha);
      chk("cmem_rd_busy", busy, 1);
      rd_n = 1;
      step(6);
      chk("cmem_rd_idle", busy, 0);
      // bypass address goes to emulation write even with cmem_bank=1
      a = 4'hd;
      tb_d = 4'h5;
      tb_den = 1;
      q.push_back('{EWR, 4'hd, 4'h5});
      wr_n = 0;
      wait_toggle(0);
      chk("wr_req_level", emu_wr_req, 1);
      step(7);
      emu_wr_ack = emu_wr_req;
      step(2);
      chk("wr_addr_out", addr_out, 4'hd);
      chk("wr_wdata_out", wdata_out, 4'h5);
      chk("wr_busy", busy, 1);
      wr_n = 1;
      step(1);
      tb_den = 0;
      step(6);
      chk("wr_idle", busy, 0);
      // emulation read with latched data
      cmem_bank = 0;
      a = 2;
      q.push_back('{ERD, 4'h2, 4'h0});
      rd_n = 0;
      wait_toggle(1);
      step(3);
      chk("emu_wait_busd", bus_d, 0);
      step(9);
      emu_rdata = 4'h9;
      emu_rd_ack = emu_rd_req;
      step(3);
      emu_rdata = 4'h0;
      chk("emu_rd_busd", bus_d, 4'h9);
      chk("emu_rd_busy", busy, 1);
      rd_n = 1;
      step(6);
      chk("emu_rd_idle", busy, 0);
      // no ack -> timeout after 16 cycles in WAIT_EMU
      a = 5;
      q.push_back('{ERD, 4'h5, 4'h0});
      q.push_back('{TMO, 4'h5, 4'h0});
      rd_n = 0;
      wait_toggle(1);
      for (n = 1; n <= 40; n++) begin
         step(1);
         if (timeout_err) break;
      end
      chk("timeout_cycles", n, 16);
      step(2);
      chk("timeout_busd", bus_d, 0);
      chk("timeout_busy", busy, 1);
      rd_n = 1;
      step(6);
      chk("timeout_idle", busy, 0);
      emu_rd_ack = emu_rd_req;
      step(5);
      chk("late_ack_busy", busy, 0);
      // one-cycle glitch, then both strobes low
      cmem_bank = 1;
      a = 3;
      rd_n = 0;
      step(1);
      rd_n = 1;
      step(10);
      chk("glitch_busy", busy, 0);
      chk("glitch_no_event", q.size(), 0);
      q.push_back('{CRD, 4'h3, 4'h0});
      rd_n = 0;
      wr_n = 0;
      step(12);
      chk("both_busd", bus_d, 4'ha);
      rd_n = 1;
      wr_n = 1;
      step(6);
      chk("both_idle", busy, 0);
      step(3);
      chk("queue_empty", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
